ex_div_ctrl: RTL and testbench
==============================

// Module: ex_div_ctrl
// PURPOSE
//  Iterative 32-bit divide sequencer attached to the EX stage. Accepts div/divu operands from the
//  EX operand mux and runs a radix-2 restoring division over 32 cycles. Produces {hi,lo} results
//  and drives stallreq_from_ex so the stall controller freezes IF..EX until the result is ready.
// PARAMETERS
//  DATA_W   32   operand/result width; only 32 is supported
//  CNT_W    6    iteration counter width; must satisfy 2**CNT_W > DATA_W
// PORTS
//  clk              in   1       clock; all state updates on posedge
//  rst              in   1       synchronous, active-high reset
//  div_start        in   1       EX holds a div/divu this cycle; level, held high while EX is stalled
//  div_signed       in   1       1 = div (signed), 0 = divu
//  div_src1         in   32      dividend (rs)
//  div_src2         in   32      divisor (rt)
//  pipe_stall       in   1       a downstream stage stalls EX (stall[3]); holds DONE
//  div_cancel       in   1       flush; aborts any operation
//  div_hi           out  32      remainder
//  div_lo           out  32      quotient
//  div_ready        out  1       result valid; EX may capture hi/lo
//  stallreq_from_ex out  1       request to freeze IF/ID/EX
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, div_hi=0, div_lo=0, div_ready=0, stallreq_from_ex=0.
//  States:
//   IDLE -> CALC when div_start & ~div_cancel. Latch |src1| and |src2| when div_signed, raw values
//     otherwise. Latch sign_q=s1^s2 and sign_r=s1 (signed only). cnt=0.
//   CALC: one restoring step per cycle on a 64-bit {rem,quo} register:
//     shift left 1; if rem[63:32] >= divisor then subtract and set quo bit0=1.
//     cnt++. After step 32 (cnt==31) -> DONE. Final sign fix-up is applied on this transition.
//   DONE: div_ready=1. If pipe_stall, stay in DONE. Otherwise -> IDLE next cycle.
//     A div_start seen while in DONE belongs to the completed instruction and is ignored.
//  Latency: start accepted at cycle T; DONE at T+33. stallreq_from_ex is high for T..T+32 and low at T+33.
//  stallreq_from_ex = (IDLE & div_start & ~div_cancel) | CALC. It is 0 in DONE.
//  Sign fix-up: lo = sign_q ? -quo : quo; hi = sign_r ? -rem : rem, each taken modulo 2^32.
//   Signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
//  Divide by zero: no trap. The restoring algorithm yields quo=0xFFFFFFFF and rem=|dividend|; the
//   sign fix-up is then applied unchanged.
//  div_hi/div_lo keep their last value until the next DONE; they are meaningful only while div_ready=1.
//  div_cancel from any state: -> IDLE next cycle, div_ready=0, stallreq_from_ex=0 in the same cycle
//   (combinational mask). If div_start and div_cancel are both high in IDLE, cancel wins.
//  A deassertion of div_start during CALC has no effect; only div_cancel aborts.
//  rst mid-operation: returns to the reset values above on the next edge.
// CONFIGURATION
//  EX_DIV_DBZ_FAST_EN defined: in IDLE, a start with div_src2==0 goes straight to DONE at T+1 and
//   loads the divide-by-zero result directly. stallreq_from_ex is high for cycle T only.
//  Not defined: divide by zero runs the full 32 iterations, DONE at T+33.
//  The result values are identical in both builds; only the latency differs.
// TESTING
//  1. divu 100/7, start at T -> stallreq high T..T+32; at T+33 ready=1, lo=0x0000000E, hi=0x00000002.
//  2. div -7/2 (0xFFFFFFF9, 2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 7/-2 -> lo=0xFFFFFFFD, hi=0x00000001.
//  3. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0x00000000; no hang, ready at T+33.
//  4. divu 5/0 -> lo=0xFFFFFFFF, hi=5; ready at T+33 without the macro, T+1 with EX_DIV_DBZ_FAST_EN.
//  5. Start at T, div_cancel at T+10 -> IDLE at T+11, stallreq=0 at T+10; a new start at T+12
//     completes correctly at T+45.
//  6. pipe_stall=1 for 3 cycles at DONE -> ready held 4 cycles with hi/lo stable, div_start ignored;
//     IDLE on the cycle after pipe_stall falls; no second division is launched.

Source files
------------

// File: rtl/ex_div_ctrl_if.sv
// rtl/ex_div_ctrl_if.sv - EX-stage to divide-sequencer handshake bundle
interface ex_div_if;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        pipe_stall;
  logic        div_cancel;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic        div_ready;
  logic        stallreq_from_ex;

  modport master (
    output div_start, div_signed, div_src1, div_src2, pipe_stall, div_cancel,
    input  div_hi, div_lo, div_ready, stallreq_from_ex
  );

  modport slave (
    input  div_start, div_signed, div_src1, div_src2, pipe_stall, div_cancel,
    output div_hi, div_lo, div_ready, stallreq_from_ex
  );
endinterface

// File: rtl/ex_div_ctrl.sv
// rtl/ex_div_ctrl.sv - iterative radix-2 restoring divider with EX stall request
// Optional EX_DIV_DBZ_FAST_EN: divide-by-zero skips the iterations and completes one cycle after start.
module ex_div_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic     clk,
  input  logic     rst,
  ex_div_if.slave  dif
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] rq;
  logic [DATA_W-1:0]   divisor;
  logic                sign_q, sign_r;
  logic [DATA_W-1:0]   hi_q, lo_q;

  logic [DATA_W-1:0]   abs1, abs2;
  logic [2*DATA_W-1:0] rq_sh, rq_step;
  logic [DATA_W-1:0]   hi_fix, lo_fix;
  logic                last_step, dbz_fast;
  logic                ready_c, stallreq_c;

  assign abs1 = (dif.div_signed && dif.div_src1[DATA_W-1]) ? -dif.div_src1 : dif.div_src1;
  assign abs2 = (dif.div_signed && dif.div_src2[DATA_W-1]) ? -dif.div_src2 : dif.div_src2;

`ifdef EX_DIV_DBZ_FAST_EN
  assign dbz_fast = (dif.div_src2 == '0);
`else
  assign dbz_fast = 1'b0;
`endif

  // One restoring step: shift, trial-subtract, keep the difference if it did not underflow.
  always_comb begin
    rq_sh   = rq << 1;
    rq_step = rq_sh;
    if (rq_sh[2*DATA_W-1:DATA_W] >= divisor) begin
      rq_step[2*DATA_W-1:DATA_W] = rq_sh[2*DATA_W-1:DATA_W] - divisor;
      rq_step[0]                 = 1'b1;
    end
  end

  assign lo_fix    = sign_q ? -rq_step[DATA_W-1:0] : rq_step[DATA_W-1:0];
  assign hi_fix    = sign_r ? -rq_step[2*DATA_W-1:DATA_W] : rq_step[2*DATA_W-1:DATA_W];
  assign last_step = (cnt == CNT_W'(DATA_W-1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Cancel masks both outputs combinationally, so a flush never sees a stale ready/stall.
  always_comb begin
    state_nxt  = state;
    ready_c    = 1'b0;
    stallreq_c = 1'b0;
    if (dif.div_cancel) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (dif.div_start) begin
          stallreq_c = 1'b1;
          state_nxt  = dbz_fast ? DONE : CALC;
        end
        CALC: begin
          stallreq_c = 1'b1;
          if (last_step) state_nxt = DONE;
        end
        DONE: begin
          ready_c = 1'b1;
          if (!dif.pipe_stall) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      rq      <= '0;
      divisor <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (!dif.div_cancel) begin
      if (state == IDLE && dif.div_start) begin
        cnt     <= '0;
        rq      <= {{DATA_W{1'b0}}, abs1};
        divisor <= abs2;
        sign_q  <= dif.div_signed & (dif.div_src1[DATA_W-1] ^ dif.div_src2[DATA_W-1]);
        sign_r  <= dif.div_signed & dif.div_src1[DATA_W-1];
        // Zero divisor: quotient of all ones, remainder |dividend|, after sign fix-up.
        if (dbz_fast) begin
          hi_q <= dif.div_src1;
          lo_q <= (dif.div_signed && dif.div_src1[DATA_W-1]) ? DATA_W'(1) : '1;
        end
      end else if (state == CALC) begin
        rq  <= rq_step;
        cnt <= cnt + 1'b1;
        if (last_step) begin
          hi_q <= hi_fix;
          lo_q <= lo_fix;
        end
      end
    end
  end

  assign dif.div_hi           = hi_q;
  assign dif.div_lo           = lo_q;
  assign dif.div_ready        = ready_c;
  assign dif.stallreq_from_ex = stallreq_c;
endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb/tb_ex_div_ctrl.sv - scoreboard bench for ex_div_ctrl against an arithmetic divide model
module tb_ex_div_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  ex_div_if dif();
  ex_div_ctrl dut (.clk(clk), .rst(rst), .dif(dif));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: truncating integer division on 64-bit values; divisor zero gives all-ones quotient.
  function automatic logic [63:0] ref_div(bit sgn, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return {a, (sgn && a[31]) ? 32'h1 : 32'hFFFF_FFFF};
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int lat_of(logic [31:0] b);
`ifdef EX_DIV_DBZ_FAST_EN
    if (b == 32'h0) return 1;
`endif
    return 33;
  endfunction

  // Issues one division the way EX does: start held until ready, optionally stalled in DONE.
  task automatic run_div(bit sgn, logic [31:0] a, logic [31:0] b, int nstall,
                         logic [31:0] ehi, logic [31:0] elo);
    exp_t e;
    int guard = 0;
    int stall_bad = 0;
    int rdy_cycles = 1;
    @(posedge clk); #1;
    dif.div_start  = 1'b1;
    dif.div_signed = sgn;
    dif.div_src1   = a;
    dif.div_src2   = b;
    dif.pipe_stall = (nstall > 0);
    e.hi = ehi; e.lo = elo; e.due = cyc + lat_of(b);
    exp_q.push_back(e);
    forever begin
      @(negedge clk);
      if (dif.div_ready) break;
      if (!dif.stallreq_from_ex) stall_bad++;
      guard++;
      if (guard > 100) break;
    end
    chk("ready_seen", 32'(guard <= 100), 32'd1);
    chk("stallreq_while_busy", stall_bad, 0);
    for (int i = 0; i < nstall; i++) begin
      @(posedge clk); #1;
      if (i == nstall - 1) dif.pipe_stall = 1'b0;
      @(negedge clk);
      if (dif.div_ready) rdy_cycles++;
    end
    chk("ready_hold_cycles", rdy_cycles, nstall + 1);
    @(posedge clk); #1;
    dif.div_start = 1'b0;
    @(negedge clk);
    chk("idle_ready", dif.div_ready, 0);
    chk("idle_stallreq", dif.stallreq_from_ex, 0);
  endtask

  task automatic run_model(bit sgn, logic [31:0] a, logic [31:0] b, int nstall);
    logic [63:0] r;
    r = ref_div(sgn, a, b);
    run_div(sgn, a, b, nstall, r[63:32], r[31:0]);
  endtask

  // Monitor: pops on the first ready cycle, then requires hi/lo to stay put while ready holds.
  initial begin
    exp_t cur;
    logic prev = 1'b0;
    cur.hi = '0; cur.lo = '0; cur.due = 0;
    forever begin
      @(negedge clk);
      if (dif.div_ready && !rst) begin
        chk("stallreq_in_done", dif.stallreq_from_ex, 0);
        if (!prev) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_ready", 32'd1, 32'd0);
          end else begin
            cur = exp_q.pop_front();
            chk("div_lo", dif.div_lo, cur.lo);
            chk("div_hi", dif.div_hi, cur.hi);
            chk("ready_cycle", cyc, cur.due);
          end
        end else begin
          chk("held_lo", dif.div_lo, cur.lo);
          chk("held_hi", dif.div_hi, cur.hi);
        end
      end
      prev = dif.div_ready;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    dif.div_start = 1'b0; dif.div_signed = 1'b0; dif.div_src1 = '0; dif.div_src2 = '0;
    dif.pipe_stall = 1'b0; dif.div_cancel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", dif.div_ready, 0);
    chk("rst_stallreq", dif.stallreq_from_ex, 0);
    chk("rst_hi", dif.div_hi, 0);
    chk("rst_lo", dif.div_lo, 0);
    @(posedge clk); #1; rst = 1'b0;

    run_div(1'b0, 32'd100, 32'd7, 0, 32'h0000_0002, 32'h0000_000E);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 32'h0000_0001, 32'hFFFF_FFFD);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0000_0000, 32'h8000_0000);
    run_div(1'b0, 32'd5, 32'd0, 0, 32'h0000_0005, 32'hFFFF_FFFF);
    run_div(1'b1, 32'hFFFF_FFFB, 32'd0, 0, 32'hFFFF_FFFB, 32'h0000_0001);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 3, 32'h0000_0000, 32'hFFFF_FFFF);

    // Cancel at T+10: stall request drops in the same cycle, new start at T+12 finishes at T+45.
    @(posedge clk); #1;
    t0 = cyc;
    dif.div_start = 1'b1; dif.div_signed = 1'b0; dif.div_src1 = 32'd1000; dif.div_src2 = 32'd3;
    while (cyc < t0 + 10) begin @(posedge clk); #1; end
    dif.div_cancel = 1'b1;
    @(negedge clk);
    chk("cancel_stallreq", dif.stallreq_from_ex, 0);
    chk("cancel_ready", dif.div_ready, 0);
    @(posedge clk); #1;
    dif.div_cancel = 1'b0; dif.div_start = 1'b0;
    @(negedge clk);
    chk("after_cancel_stallreq", dif.stallreq_from_ex, 0);
    chk("restart_cycle", cyc, t0 + 11);
    run_div(1'b0, 32'd1000, 32'd3, 0, 32'd1, 32'd333);

    // Reset in the middle of an operation wipes the previous result.
    @(posedge clk); #1;
    dif.div_start = 1'b1; dif.div_signed = 1'b1; dif.div_src1 = 32'h1234_5678; dif.div_src2 = 32'd9;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1; dif.div_start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_hi", dif.div_hi, 0);
    chk("midrst_lo", dif.div_lo, 0);
    chk("midrst_stallreq", dif.stallreq_from_ex, 0);
    repeat (40) @(negedge clk);
    chk("midrst_no_ready", exp_q.size(), 0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b;
      bit sgn;
      sgn = $urandom_range(0, 1) == 1;
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: b = $urandom;
      endcase
      run_model(sgn, a, b, (n % 5 == 0) ? $urandom_range(1, 3) : 0);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
